// File: rtl/inst_mem_loader.sv
// Streams a framed big-endian instruction image into word-addressed instruction memory
// and holds the core in reset until the whole image has been written.
module inst_mem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              load_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);
    localparam int          IDX_W    = ADDR_W + 1;
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;

    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;

    logic              xfer;
    logic [15:0]       full_count;

    // byte_ready is a flop, so the handshake never loops back through byte_valid
    assign xfer       = byte_valid & byte_ready_q;
    assign full_count = {count_q[15:8], byte_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_HDR_HI;
            count_q      <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            cpu_rst_q    <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        unique case (state_q)
            S_HDR_HI: begin
                if (xfer) begin
                    count_d[15:8] = byte_data;
                    state_d       = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d[7:0] = byte_data;
                    if (full_count == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, full_count} > CAPACITY) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        widx_d  = '0;
                        bidx_d  = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d = {word_q[23:0], byte_data};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                widx_d = widx_q + 1'b1;
                // widen both sides so a full-capacity image compares without wrap
                if (17'(widx_q) + 17'd1 == {1'b0, count_q}) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE, S_ERR: begin
                if (load_req) begin
                    state_d = S_HDR_HI;
                    widx_d  = '0;
                end
            end
            default: state_d = S_HDR_HI;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        byte_ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                       (state_d == S_DATA)   || (state_d == S_ERR);
        mem_we_d     = (state_d == S_WRITE);
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        if (state_d == S_WRITE) begin
            mem_waddr_d = widx_q[ADDR_W-1:0];
            mem_wdata_d = word_d;
        end
        cpu_rst_d    = (state_d != S_DONE);
        load_done_d  = (state_d == S_DONE);
        load_err_d   = (state_d == S_ERR);
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: expected memory writes are queued as bytes are sent
// and matched against every mem_we pulse.
module tb_inst_mem_loader;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              load_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .load_req(load_req),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Called #1 after a posedge; returns #1 after the posedge that transferred the byte
    task automatic send(input logic [7:0] b);
        int guard = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        $display("sent byte %h", b);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]); send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_we", {22'd0, mem_waddr}, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] ea, ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("waddr", {22'd0, mem_waddr}, ea);
                check("wdata", mem_wdata, ed);
                $display("write addr=%0d data=%h", mem_waddr, mem_wdata);
            end
        end
    end

    initial begin
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        load_req   = 1'b0;
        idle(2);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_waddr", {22'd0, mem_waddr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        rst = 1'b1;
        idle(1);
        check("hdr_ready", {31'd0, byte_ready}, 32'd1);

        // Normal two-word image
        expect_write(32'd0, 32'h3C020404);
        expect_write(32'd1, 32'h34420404);
        send(8'h00); send(8'h02);
        send_word(32'h3C020404);
        send(8'h34); send(8'h42); send(8'h04);
        check("norm_cpu_rst_loading", {31'd0, cpu_rst}, 32'd1);
        send(8'h04);
        check("norm_we_in_write", {31'd0, mem_we}, 32'd1);
        check("norm_ready_in_write", {31'd0, byte_ready}, 32'd0);
        check("norm_done_not_yet", {31'd0, load_done}, 32'd0);
        idle(1);
        check("norm_done", {31'd0, load_done}, 32'd1);
        check("norm_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("norm_we_off", {31'd0, mem_we}, 32'd0);
        check("norm_waddr_hold", {22'd0, mem_waddr}, 32'd1);
        check("norm_wdata_hold", mem_wdata, 32'h34420404);

        // DONE ignores the source
        byte_valid = 1'b1; byte_data = 8'h55;
        idle(3);
        check("done_ready", {31'd0, byte_ready}, 32'd0);
        check("done_hold", {31'd0, load_done}, 32'd1);
        byte_valid = 1'b0;

        // Reload
        pulse_load_req();
        check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("reload_done_clr", {31'd0, load_done}, 32'd0);
        expect_write(32'd0, 32'h00000000);
        send(8'h00); send(8'h01);
        send_word(32'h00000000);
        check("reload_we", {31'd0, mem_we}, 32'd1);
        idle(1);
        check("reload_done", {31'd0, load_done}, 32'd1);
        check("reload_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);

        // Zero-length image
        pulse_load_req();
        send(8'h00); send(8'h00);
        check("zero_done", {31'd0, load_done}, 32'd1);
        check("zero_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check("zero_we", {31'd0, mem_we}, 32'd0);

        // Overflow: 1025 words
        pulse_load_req();
        send(8'h04); send(8'h01);
        check("ovf_err", {31'd0, load_err}, 32'd1);
        check("ovf_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("ovf_done", {31'd0, load_done}, 32'd0);
        check("ovf_ready", {31'd0, byte_ready}, 32'd1);
        send(8'h11);
        check("ovf_ready_11", {31'd0, byte_ready}, 32'd1);
        send(8'h22);
        check("ovf_ready_22", {31'd0, byte_ready}, 32'd1);
        send(8'h33);
        check("ovf_err_hold", {31'd0, load_err}, 32'd1);
        pulse_load_req();
        check("ovf_err_clr", {31'd0, load_err}, 32'd0);
        check("ovf_cpu_rst_after", {31'd0, cpu_rst}, 32'd1);

        // Throttled one-word image, valid every other cycle
        expect_write(32'd0, 32'hDEADBEEF);
        send(8'h00); idle(1); send(8'h01); idle(1);
        send(8'hDE); idle(1); send(8'hAD); idle(1); send(8'hBE); idle(1);
        send(8'hEF);
        check("thr_we", {31'd0, mem_we}, 32'd1);
        check("thr_ready_write", {31'd0, byte_ready}, 32'd0);
        idle(1);
        check("thr_done", {31'd0, load_done}, 32'd1);

        // Asynchronous reset mid-word
        pulse_load_req();
        send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
        idle(2);
        check("partial_no_done", {31'd0, load_done}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        check("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("mid_rst_waddr", {22'd0, mem_waddr}, 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        expect_write(32'd0, 32'h01020304);
        send(8'h00); send(8'h01);
        send_word(32'h01020304);
        idle(1);
        check("fresh_done", {31'd0, load_done}, 32'd1);

        // Full-capacity image: 1024 words, last address 1023
        pulse_load_req();
        send(8'h04); send(8'h00);
        check("cap_no_err", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = 32'(i) * 32'h9E3779B1;
            expect_write(32'(i), w);
            send_word(w);
        end
        check("cap_last_addr", {22'd0, mem_waddr}, 32'd1023);
        idle(1);
        check("cap_done", {31'd0, load_done}, 32'd1);
        check("cap_cpu_rst", {31'd0, cpu_rst}, 32'd0);

        idle(2);
        check("queue_empty", 32'(exp_addr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
